data_mem_responder: RTL and testbench

Data-side memory responder, the slave end of the processor's data port. It answers the ReadData/WriteData/DataAddr/DataOut requests and returns DataIn and DataWaitreq. It models a word-addressed RAM with a configurable number of wait states, so the processor's Memory-stage stall path gets exercised. It sits between the processor core and the testbench or top level, alongside the instruction memory.

---
 rtl/data_mem_responder.sv | 144 ++++++++++++++
 tb/tb_data_mem_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-side memory responder: word-addressed RAM behind a Waitreq handshake with WAIT_STATES wait cycles.
// Optional access statistics ports are enabled by defining DATA_MEM_STATS_EN.
module data_mem_responder #(
    parameter int WORD_SIZE   = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 ReadData,
    input  logic                 WriteData,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,
    output logic                 Error
`ifdef DATA_MEM_STATS_EN
    ,
    output logic [WORD_SIZE-1:0] ReadCount,
    output logic [WORD_SIZE-1:0] WriteCount,
    output logic [31:0]          WaitCount
`endif
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit         NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [1:0]           state;
    logic [3:0]           cnt;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] rdata;
    logic                 op_q;
    logic                 req;
    logic                 accept;
    logic                 acc_write;
    logic                 commit_en;
    logic [WORD_SIZE-1:0] commit_addr;
    logic [WORD_SIZE-1:0] commit_data;

    function automatic logic in_range(input logic [WORD_SIZE-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    function automatic logic [WORD_SIZE-1:0] read_word(input logic [WORD_SIZE-1:0] a,
                                                       input logic is_write);
        return (!is_write && in_range(a)) ? mem[a[AW-1:0]] : '0;
    endfunction

    assign req         = ReadData | WriteData;
    assign accept      = req && (state == ACK || NO_WAIT);
    assign DataWaitreq = req && !(state == ACK || NO_WAIT);
    assign acc_write   = NO_WAIT ? WriteData : op_q;

    always_comb begin
        DataIn = '0;
        if (NO_WAIT) begin
            if (ReadData) DataIn = read_word(DataAddr, WriteData);
        end else if (state == ACK && req) begin
            DataIn = rdata;
        end
    end

    always_comb begin
        commit_en   = 1'b0;
        commit_addr = NO_WAIT ? DataAddr : addr_q;
        commit_data = NO_WAIT ? DataOut : wdata_q;
        if (!Reset && accept && acc_write && in_range(commit_addr)) commit_en = 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (commit_en) mem[commit_addr[AW-1:0]] <= commit_data;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            op_q    <= 1'b0;
            wdata_q <= '0;
            rdata   <= '0;
            Error   <= 1'b0;
        end else begin
            if (state == IDLE && req && ((ReadData && WriteData) || !in_range(DataAddr)))
                Error <= 1'b1;
            case (state)
                IDLE: begin
                    if (req && !NO_WAIT) begin
                        addr_q  <= DataAddr;
                        op_q    <= WriteData;
                        wdata_q <= DataOut;
                        cnt     <= CNT_INIT;
                        if (WAIT_STATES == 1) begin
                            rdata <= read_word(DataAddr, WriteData);
                            state <= ACK;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!req) begin
                        state <= IDLE;
                        rdata <= '0;
                    end else begin
                        // Leave on the last count so Waitreq spans exactly WAIT_STATES cycles.
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            rdata <= read_word(addr_q, op_q);
                            state <= ACK;
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                    rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DATA_MEM_STATS_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ReadCount  <= '0;
            WriteCount <= '0;
            WaitCount  <= '0;
        end else begin
            if (accept && !acc_write && ReadCount != '1) ReadCount <= ReadCount + WORD_SIZE'(1);
            if (accept && acc_write && WriteCount != '1) WriteCount <= WriteCount + WORD_SIZE'(1);
            if (DataWaitreq && WaitCount != '1) WaitCount <= WaitCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (2, 0 and 3 wait states) checked against a transaction-level RAM model.
module tb_data_mem_responder;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [2:0]  rd = '0, wr = '0, wreq, err;
    logic [15:0] addr [3];
    logic [15:0] dout [3];
    logic [15:0] din  [3];
`ifdef DATA_MEM_STATS_EN
    logic [15:0] rcnt [3];
    logic [15:0] wcnt [3];
    logic [31:0] wtcnt [3];
`endif

    int          ws_tab [3] = '{2, 0, 3};
    logic [15:0] ref_mem [3][256];
    logic        ref_err [3] = '{1'b0, 1'b0, 1'b0};
    int          checks = 0;
    int          errors = 0;

    always #5 Clock = ~Clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .WORD_SIZE(16),
            .DEPTH(256),
            .WAIT_STATES((g == 0) ? 2 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .Clock(Clock),
            .Reset(Reset),
            .ReadData(rd[g]),
            .WriteData(wr[g]),
            .DataAddr(addr[g]),
            .DataOut(dout[g]),
            .DataIn(din[g]),
            .DataWaitreq(wreq[g]),
            .Error(err[g])
`ifdef DATA_MEM_STATS_EN
            ,
            .ReadCount(rcnt[g]),
            .WriteCount(wcnt[g]),
            .WaitCount(wtcnt[g])
`endif
        );
    end

    typedef struct {
        bit          rst;
        bit          r;
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp_din;
        bit          exp_err;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: a RAM where each request is one atomic transaction.
    function automatic logic [15:0] model(input int k, input bit r, input bit w,
                                          input logic [15:0] a, input logic [15:0] d);
        logic [15:0] res = '0;
        if ((r && w) || a >= 16'd256) ref_err[k] = 1'b1;
        if (a < 16'd256) begin
            if (w) ref_mem[k][a[7:0]] = d;
            else if (r) res = ref_mem[k][a[7:0]];
        end
        return res;
    endfunction

    // Entered and left on a falling edge; request stays asserted on return.
    task automatic access(input int k, input bit r, input bit w, input logic [15:0] a,
                          input logic [15:0] d, input int abort_after,
                          output logic [15:0] got_din, output logic got_err);
        int waits = 0;
        bit done = 0;
        rd[k] = r; wr[k] = w; addr[k] = a; dout[k] = d;
        got_din = '0;
        while (!done) begin
            #1;
            if (wreq[k]) begin
                waits++;
                if (waits > 40) begin
                    checks++; errors++;
                    $display("FAIL wait_bound dut %0d waitreq still high after %0d cycles", k, waits);
                    got_err = err[k];
                    return;
                end
                @(negedge Clock);
                if (abort_after >= 0 && waits == abort_after) begin
                    rd[k] = 1'b0; wr[k] = 1'b0;
                    #1;
                    check("abort_waitreq", 32'(wreq[k]), 32'd0);
                    check("abort_din", 32'(din[k]), 32'd0);
                    @(negedge Clock);
                    got_err = err[k];
                    return;
                end
            end else begin
                got_din = din[k];
                @(negedge Clock);
                done = 1;
            end
        end
        got_err = err[k];
        check("wait_cycles", 32'(waits), 32'(ws_tab[k]));
    endtask

    task automatic idle(input int k);
        rd[k] = 1'b0; wr[k] = 1'b0;
        @(negedge Clock);
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) ref_err[k] = 1'b0;
    endtask

    task automatic init_mem(input int k);
        logic [15:0] gd;
        logic        ge;
        for (int a = 0; a < 256; a++) begin
            access(k, 1'b0, 1'b1, 16'(a), 16'h0000, -1, gd, ge);
            ref_mem[k][a] = '0;
            idle(k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] gd, exp;
        logic        ge;
        bit          r, w;
        logic [15:0] a, d;

        for (int k = 0; k < 3; k++) begin
            addr[k] = '0; dout[k] = '0;
        end
        tbl[0] = '{0, 0, 1, 16'd5,   16'hBEEF, 16'h0000, 0};
        tbl[1] = '{0, 1, 0, 16'd5,   16'h0000, 16'hBEEF, 0};
        tbl[2] = '{0, 1, 0, 16'd6,   16'h0000, 16'h0000, 0};
        tbl[3] = '{0, 1, 1, 16'd9,   16'hA5A5, 16'h0000, 1};
        tbl[4] = '{0, 1, 0, 16'd9,   16'h0000, 16'hA5A5, 1};
        tbl[5] = '{1, 1, 0, 16'd5,   16'h0000, 16'hBEEF, 0};
        tbl[6] = '{0, 1, 0, 16'd300, 16'h0000, 16'h0000, 1};
        tbl[7] = '{0, 0, 1, 16'd300, 16'h1111, 16'h0000, 1};
        tbl[8] = '{0, 1, 0, 16'd44,  16'h0000, 16'h0000, 1};
        tbl[9] = '{1, 1, 0, 16'd44,  16'h0000, 16'h0000, 0};

        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset_waitreq", 32'(wreq[k]), 32'd0);
            check("reset_din", 32'(din[k]), 32'd0);
            check("reset_err", 32'(err[k]), 32'd0);
        end
        @(negedge Clock);

        fork
            init_mem(0);
            init_mem(1);
            init_mem(2);
        join

        // Directed table on the 2-wait-state instance.
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst) pulse_reset();
            access(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, -1, gd, ge);
            exp = model(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
            idle(0);
            check($sformatf("tbl%0d_din", i), 32'(gd), 32'(tbl[i].exp_din));
            check($sformatf("tbl%0d_err", i), 32'(ge), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_errhold", i), 32'(err[0]), 32'(tbl[i].exp_err));
        end

        // Zero wait states: back-to-back accesses, read data in the same cycle.
        access(1, 1'b0, 1'b1, 16'd1, 16'h0011, -1, gd, ge);
        exp = model(1, 1'b0, 1'b1, 16'd1, 16'h0011);
        access(1, 1'b0, 1'b1, 16'd2, 16'h0022, -1, gd, ge);
        exp = model(1, 1'b0, 1'b1, 16'd2, 16'h0022);
        access(1, 1'b1, 1'b0, 16'd1, 16'h0000, -1, gd, ge);
        exp = model(1, 1'b1, 1'b0, 16'd1, 16'h0000);
        check("ws0_read_addr1", 32'(gd), 32'h0011);
        check("ws0_err", 32'(ge), 32'd0);
        idle(1);

        // Back-to-back on the 2-wait instance: request never deasserted.
        access(0, 1'b0, 1'b1, 16'd30, 16'h3030, -1, gd, ge);
        exp = model(0, 1'b0, 1'b1, 16'd30, 16'h3030);
        access(0, 1'b1, 1'b0, 16'd30, 16'h0000, -1, gd, ge);
        exp = model(0, 1'b1, 1'b0, 16'd30, 16'h0000);
        check("b2b_read", 32'(gd), 32'h3030);
        idle(0);

        // Three wait states: aborted write must not commit.
        access(2, 1'b0, 1'b1, 16'd7, 16'h1234, 1, gd, ge);
        access(2, 1'b1, 1'b0, 16'd7, 16'h0000, -1, gd, ge);
        exp = model(2, 1'b1, 1'b0, 16'd7, 16'h0000);
        check("abort_read_addr7", 32'(gd), 32'h0000);
        idle(2);

        // Reset in the middle of a write: nothing committed.
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 16'd12; dout[0] = 16'h7777;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0; wr[0] = 1'b0;
        for (int k = 0; k < 3; k++) ref_err[k] = 1'b0;
        @(negedge Clock);
        access(0, 1'b1, 1'b0, 16'd12, 16'h0000, -1, gd, ge);
        idle(0);
        check("rst_mid_read", 32'(gd), 32'h0000);
        check("rst_mid_err", 32'(ge), 32'd0);

        // Randomised traffic against the model.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 50; n++) begin
                r = 1'($urandom_range(0, 1));
                w = !r;
                if ($urandom_range(0, 15) == 0) begin r = 1'b1; w = 1'b1; end
                a = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(256, 1000))
                                                 : 16'($urandom_range(0, 255));
                d = 16'($urandom);
                access(k, r, w, a, d, -1, gd, ge);
                exp = model(k, r, w, a, d);
                check("rnd_din", 32'(gd), 32'(exp));
                check("rnd_err", 32'(ge), 32'(ref_err[k]));
                if ($urandom_range(0, 1) == 1) idle(k);
            end
            idle(k);
        end

`ifdef DATA_MEM_STATS_EN
        pulse_reset();
        access(0, 1'b0, 1'b1, 16'd20, 16'h0001, -1, gd, ge); idle(0);
        access(0, 1'b0, 1'b1, 16'd21, 16'h0002, -1, gd, ge); idle(0);
        access(0, 1'b1, 1'b0, 16'd20, 16'h0000, -1, gd, ge); idle(0);
        access(0, 1'b1, 1'b0, 16'd21, 16'h0000, -1, gd, ge); idle(0);
        access(0, 1'b1, 1'b0, 16'd22, 16'h0000, -1, gd, ge); idle(0);
        check("stats_reads", 32'(rcnt[0]), 32'd3);
        check("stats_writes", 32'(wcnt[0]), 32'd2);
        check("stats_waits", wtcnt[0], 32'd10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
